// File: rtl/array_stream_bridge.sv
// Responder-side bridge: turns single Array requests into request-stream beats and completes them from the response stream.
// Optional feature macro: ARRAY_BRIDGE_WRITE_ACK_EN (writes also wait for a response beat).
`ifndef addrN
`define addrN 8
`endif
`ifndef intN
`define intN 8
`endif

module array_stream_bridge #(
   parameter int AN = `addrN,
   parameter int DN = `intN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AN-1:0] arr_addr,
   input  logic          arr_we,
   input  logic [DN-1:0] arr_di,
   input  logic          arr_valid,
   output logic [DN-1:0] arr_do,
   output logic          arr_ready,
   output logic [AN-1:0] req_addr,
   output logic          req_we,
   output logic [DN-1:0] req_di,
   output logic          req_valid,
   input  logic          req_ready,
   input  logic [DN-1:0] rsp_data,
   input  logic          rsp_valid,
   output logic          rsp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

`ifdef ARRAY_BRIDGE_WRITE_ACK_EN
   localparam state_t WR_NEXT = WAIT;
`else
   localparam state_t WR_NEXT = DONE;
`endif

   state_t          state_r;
   state_t          state_s;
   logic [AN-1:0]   addr_r;
   logic            we_r;
   logic [DN-1:0]   di_r;
   logic [DN-1:0]   rdata_r;
   logic            arr_ready_r;
   logic            req_valid_r;
   logic            rsp_ready_r;

   // next-state decode for the single-outstanding transaction sequence
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (arr_valid) begin
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (req_ready) begin
               if (we_r) begin
                  state_s = WR_NEXT;
               end else begin
                  state_s = WAIT;
               end
            end else begin
               state_s = REQ;
            end
         end
         WAIT: begin
            if (rsp_valid) begin
               state_s = DONE;
            end else begin
               state_s = WAIT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // state, holding registers, read data and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         addr_r      <= {AN{1'b0}};
         we_r        <= 1'b0;
         di_r        <= {DN{1'b0}};
         rdata_r     <= {DN{1'b0}};
         arr_ready_r <= 1'b0;
         req_valid_r <= 1'b0;
         rsp_ready_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         // handshake flags are registered copies of the next-state decode
         arr_ready_r <= (state_s == DONE);
         req_valid_r <= (state_s == REQ);
         rsp_ready_r <= (state_s == WAIT);
         if ((state_r == IDLE) && arr_valid) begin
            addr_r <= arr_addr;
            we_r   <= arr_we;
            di_r   <= arr_di;
         end
         // write acknowledgements carry no data and must not disturb arr_do
         if ((state_r == WAIT) && rsp_valid && (we_r == 1'b0)) begin
            rdata_r <= rsp_data;
         end
      end
   end

   assign arr_do    = rdata_r;
   assign arr_ready = arr_ready_r;
   assign req_addr  = addr_r;
   assign req_we    = we_r;
   assign req_di    = di_r;
   assign req_valid = req_valid_r;
   assign rsp_ready = rsp_ready_r;

endmodule
